trap_sequencer: RTL

- Machine-mode trap/return controller for the RV32 core.
- Turns one-cycle exception, interrupt and mret events into an ordered sequence of single-port writes to the CSR register file (mepc, mcause, mtval, mstatus), then issues a PC redirect.
- Stalls the pipeline while the sequence runs.

---
 rtl/trap_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: M-mode trap/mret controller sequencing CSR writes then a PC redirect.
// Optional VECTORED_MTVEC_EN: vectored mtvec mode for interrupts.
module trap_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  input  logic                  exc_illegal,
  input  logic                  exc_ecall,
  input  logic                  exc_lfault,
  input  logic                  exc_sfault,
  input  logic                  ext_irq,
  input  logic                  mret,
  input  logic [31:0]           pc,
  input  logic [31:0]           inst,
  input  logic [31:0]           badaddr,
  input  logic [31:0]           mstatus_in,
  input  logic [31:0]           mtvec_in,
  input  logic [31:0]           mepc_in,
  output logic                  csr_w,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [31:0]           csr_wdata,
  output logic [1:0]            csr_wsc_mode,
  output logic                  stall,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, REDIRECT} state_t;
  localparam logic [CSR_ADDR_W-1:0] A_MSTATUS = CSR_ADDR_W'(12'h300);
  localparam logic [CSR_ADDR_W-1:0] A_MEPC    = CSR_ADDR_W'(12'h341);
  localparam logic [CSR_ADDR_W-1:0] A_MCAUSE  = CSR_ADDR_W'(12'h342);
  localparam logic [CSR_ADDR_W-1:0] A_MTVAL   = CSR_ADDR_W'(12'h343);
  state_t state;
  logic [31:0] cause_q, tval_q, mst_q;
  logic irq_q;
  logic ev, trap, ret;
  logic [31:0] cause_n, tval_n, mst_trap, mst_ret, base, tvec, trap_pc;
  assign csr_wsc_mode = 2'b01;
  assign busy = state != IDLE;
  assign ev = inst_valid && state == IDLE;
  assign trap = ev && (exc_illegal || exc_ecall || exc_lfault || exc_sfault || (ext_irq && mstatus_in[3]));
  assign ret = ev && mret && !trap;
  assign stall = busy || trap || ret;
  assign cause_n = exc_illegal ? 32'd2 : exc_ecall ? 32'd11 : exc_lfault ? 32'd5 : exc_sfault ? 32'd7 : 32'h8000_000B;
  assign tval_n = exc_illegal ? inst : exc_ecall ? 32'd0 : (exc_lfault || exc_sfault) ? badaddr : 32'd0;
  assign mst_trap = {mst_q[31:13], 2'b11, mst_q[10:8], mst_q[3], mst_q[6:4], 1'b0, mst_q[2:0]};
  assign mst_ret = {mstatus_in[31:13], 2'b11, mstatus_in[10:8], 1'b1, mstatus_in[6:4], mstatus_in[7], mstatus_in[2:0]};
  assign base = mtvec_in & 32'hFFFF_FFFC;
`ifdef VECTORED_MTVEC_EN
  assign tvec = (mtvec_in[1:0] == 2'b01 && irq_q) ? base + {cause_q[29:0], 2'b00} : base;
`else
  assign tvec = base;
`endif
  assign trap_pc = base == 32'd0 ? RESET_VEC : tvec;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      csr_w <= 1'b0;
      csr_waddr <= '0;
      csr_wdata <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      cause_q <= '0;
      tval_q <= '0;
      mst_q <= '0;
      irq_q <= 1'b0;
    end else begin
      csr_w <= 1'b0;
      csr_waddr <= '0;
      csr_wdata <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      case (state)
        IDLE:
          if (trap) begin
            cause_q <= cause_n;
            tval_q <= tval_n;
            mst_q <= mstatus_in;
            irq_q <= cause_n[31];
            state <= W_MEPC;
            csr_w <= 1'b1;
            csr_waddr <= A_MEPC;
            csr_wdata <= {pc[31:2], 2'b00};
          end else if (ret) begin
            state <= R_MSTATUS;
            csr_w <= 1'b1;
            csr_waddr <= A_MSTATUS;
            csr_wdata <= mst_ret;
          end
        W_MEPC: begin
          state <= W_MCAUSE;
          csr_w <= 1'b1;
          csr_waddr <= A_MCAUSE;
          csr_wdata <= cause_q;
        end
        W_MCAUSE: begin
          state <= W_MTVAL;
          csr_w <= 1'b1;
          csr_waddr <= A_MTVAL;
          csr_wdata <= tval_q;
        end
        W_MTVAL: begin
          state <= W_MSTATUS;
          csr_w <= 1'b1;
          csr_waddr <= A_MSTATUS;
          csr_wdata <= mst_trap;
        end
        W_MSTATUS: begin
          state <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc <= trap_pc;
        end
        R_MSTATUS: begin
          state <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc <= mepc_in;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
